// File: rtl/nano_int_ctrl_n.sv
// N-channel external interrupt controller: synchronised edge/level capture, io-mapped
// MASK/PEND/POL/TRIG/STAT/EOI registers, fixed-priority arbitration and a single in-service FSM.
module nano_int_ctrl_n #(
    parameter int          N_CH        = 3,
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  BASE_ADD    = 8'h00
) (
    input  logic            CLK,
    input  logic            NRST,
    input  logic [7:0]      add,
    input  logic [7:0]      data_i,
    input  logic            we,
    output logic [7:0]      data_o,
    input  logic [N_CH-1:0] eint,
    input  logic            ack,
    output logic            irq,
    output logic [2:0]      irq_id,
    output logic [N_CH-1:0] int_vec
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        BUSY   = 2'b10,
        UNUSED = 2'b11
    } state_t;

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q, sync_d;
    logic [N_CH-1:0] prev_q, prev_d;
    logic [N_CH-1:0] mask_q, mask_d, pend_q, pend_d, pol_q, pol_d, trig_q, trig_d;
    state_t          state_q, state_d;
    logic            irq_q, irq_d;
    logic [2:0]      irq_id_q, irq_id_d;
    logic [N_CH-1:0] int_vec_q, int_vec_d;
    logic [7:0]      data_o_q, data_o_d;

    logic [7:0]      off;
    logic [N_CH-1:0] s, hit, cand, w1c, ack_clr;
    logic [2:0]      pri;
    logic            any_cand, eoi_wr;

    assign off      = add - BASE_ADD;
    assign s        = sync_q[SYNC_STAGES-1];
    // Normalise by POL so a single "0 -> 1" test covers both rising and falling edges.
    assign hit      = (s ^ pol_q) & ~(prev_q ^ pol_q);
    assign cand     = pend_q & mask_q;
    assign any_cand = |cand;
    assign w1c      = (we && off == 8'd1) ? data_i[N_CH-1:0] : '0;
    assign eoi_wr   = we && off == 8'd5;

    always_comb begin
        pri = 3'd0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (cand[i]) pri = 3'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        ack_clr = '0;
        case (state_q)
            IDLE: if (any_cand) state_d = REQ;
            REQ: begin
                if (!any_cand) begin
                    state_d = IDLE;
                end else if (ack) begin
                    state_d = BUSY;
                    for (int i = 0; i < N_CH; i++) begin
                        if (irq_id_q == 3'(i)) ack_clr[i] = 1'b1;
                    end
                end
            end
            BUSY:    if (eoi_wr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = eint;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        prev_d = s;
        mask_d = (we && off == 8'd0) ? data_i[N_CH-1:0] : mask_q;
        pol_d  = (we && off == 8'd2) ? data_i[N_CH-1:0] : pol_q;
        trig_d = (we && off == 8'd3) ? data_i[N_CH-1:0] : trig_q;
        // Level channels track the pin; edge channels latch, and a new hit beats any clear.
        for (int i = 0; i < N_CH; i++) begin
            if (trig_q[i]) pend_d[i] = s[i] ^ pol_q[i];
            else           pend_d[i] = (pend_q[i] & ~w1c[i] & ~ack_clr[i]) | hit[i];
        end
    end

    always_comb begin
        irq_d     = (state_d == REQ);
        irq_id_d  = 3'd0;
        int_vec_d = '0;
        if (state_d == REQ)       irq_id_d = pri;
        else if (state_d == BUSY) irq_id_d = irq_id_q;
        for (int i = 0; i < N_CH; i++) begin
            if (irq_d && irq_id_d == 3'(i)) int_vec_d[i] = 1'b1;
        end
        case (off)
            8'd0:    data_o_d = 8'(mask_q);
            8'd1:    data_o_d = 8'(pend_q);
            8'd2:    data_o_d = 8'(pol_q);
            8'd3:    data_o_d = 8'(trig_q);
            8'd4:    data_o_d = {irq_q, state_q, 2'b00, irq_id_q};
            default: data_o_d = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            sync_q    <= '0;
            prev_q    <= '0;
            mask_q    <= '0;
            pend_q    <= '0;
            pol_q     <= '0;
            trig_q    <= '0;
            state_q   <= IDLE;
            irq_q     <= 1'b0;
            irq_id_q  <= 3'd0;
            int_vec_q <= '0;
            data_o_q  <= 8'h00;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            mask_q    <= mask_d;
            pend_q    <= pend_d;
            pol_q     <= pol_d;
            trig_q    <= trig_d;
            state_q   <= state_d;
            irq_q     <= irq_d;
            irq_id_q  <= irq_id_d;
            int_vec_q <= int_vec_d;
            data_o_q  <= data_o_d;
        end
    end

    assign data_o  = data_o_q;
    assign irq     = irq_q;
    assign irq_id  = irq_id_q;
    assign int_vec = int_vec_q;

endmodule

// File: tb/tb_nano_int_ctrl_n.sv
// Scenario bench for nano_int_ctrl_n: a 3-channel and an 8-channel instance share the io bus;
// read expectations are queued when a read is driven and popped when data_o is registered.
module tb_nano_int_ctrl_n;

    logic       CLK = 1'b0;
    logic       NRST = 1'b0;
    logic [7:0] add = 8'h00;
    logic [7:0] data_i = 8'h00;
    logic       we = 1'b0;
    logic       ack = 1'b0;
    logic [2:0] eint = 3'b000;
    logic [7:0] eint8 = 8'h00;

    logic [7:0] data_o, data_o8;
    logic       irq, irq8;
    logic [2:0] irq_id, irq_id8;
    logic [2:0] int_vec;
    logic [7:0] int_vec8;

    int         vec = 0;
    int         miss = 0;
    logic [7:0] sb[$];
    logic [7:0] e;

    nano_int_ctrl_n #(.N_CH(3), .SYNC_STAGES(2), .BASE_ADD(8'h00)) dut3 (
        .CLK(CLK), .NRST(NRST), .add(add), .data_i(data_i), .we(we), .data_o(data_o),
        .eint(eint), .ack(ack), .irq(irq), .irq_id(irq_id), .int_vec(int_vec)
    );

    nano_int_ctrl_n #(.N_CH(8), .SYNC_STAGES(2), .BASE_ADD(8'h00)) dut8 (
        .CLK(CLK), .NRST(NRST), .add(add), .data_i(data_i), .we(we), .data_o(data_o8),
        .eint(eint8), .ack(ack), .irq(irq8), .irq_id(irq_id8), .int_vec(int_vec8)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        add = a; data_i = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    // Queue the value data_o must show once the read has been registered.
    task automatic rd(input logic [7:0] a, input logic [7:0] x);
        add = a;
        sb.push_back(x);
        tick();
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        NRST = 1'b0;
        ticks(3);
        vec++; if (data_o !== 8'h00) begin miss++; $display("FAIL rst_data_o got %h want 00", data_o); end
        vec++; if ({irq, irq_id, int_vec} !== 7'd0) begin miss++; $display("FAIL rst_irq got %b/%0d/%b want 0/0/000", irq, irq_id, int_vec); end
        vec++; if ({irq8, irq_id8, int_vec8} !== 12'd0) begin miss++; $display("FAIL rst_irq8 got %b/%0d/%h want 0/0/00", irq8, irq_id8, int_vec8); end
        NRST = 1'b1;
        tick();
        rd(8'h04, 8'h00);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL rst_stat got %h want %h", data_o, e); end
    endtask

    task automatic test_single_edge();
        wr(8'h00, 8'h07);
        eint[1] = 1'b1;
        ticks(3);
        vec++; if (irq !== 1'b0) begin miss++; $display("FAIL s1_irq_early got %b want 0", irq); end
        rd(8'h01, 8'h02);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s1_pend got %h want %h", data_o, e); end
        vec++; if ({irq, irq_id, int_vec} !== {1'b1, 3'd1, 3'b010}) begin miss++; $display("FAIL s1_req got %b/%0d/%b want 1/1/010", irq, irq_id, int_vec); end
        pulse_ack();
        vec++; if ({irq, int_vec} !== 4'b0000) begin miss++; $display("FAIL s1_ack_irq got %b/%b want 0/000", irq, int_vec); end
        rd(8'h01, 8'h00);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s1_pend_clr got %h want %h", data_o, e); end
        rd(8'h04, 8'h41);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s1_stat_busy got %h want %h", data_o, e); end
        wr(8'h05, 8'h00);
        rd(8'h04, 8'h00);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s1_stat_idle got %h want %h", data_o, e); end
        eint[1] = 1'b0;
        ticks(4);
    endtask

    task automatic test_priority_back_to_back();
        eint = 3'b101;
        ticks(3);
        rd(8'h01, 8'h05);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s2_pend got %h want %h", data_o, e); end
        vec++; if ({irq, irq_id, int_vec} !== {1'b1, 3'd0, 3'b001}) begin miss++; $display("FAIL s2_req0 got %b/%0d/%b want 1/0/001", irq, irq_id, int_vec); end
        pulse_ack();
        rd(8'h01, 8'h04);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s2_pend_after_ack got %h want %h", data_o, e); end
        wr(8'h05, 8'h00);
        vec++; if (irq !== 1'b0) begin miss++; $display("FAIL s2_idle_gap got %b want 0", irq); end
        rd(8'h04, 8'h00);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s2_stat_gap got %h want %h", data_o, e); end
        vec++; if ({irq, irq_id, int_vec} !== {1'b1, 3'd2, 3'b100}) begin miss++; $display("FAIL s2_req2 got %b/%0d/%b want 1/2/100", irq, irq_id, int_vec); end
        rd(8'h04, 8'hA2);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s2_stat_req got %h want %h", data_o, e); end
        pulse_ack();
        rd(8'h01, 8'h00);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s2_pend_final got %h want %h", data_o, e); end
        wr(8'h05, 8'h00);
        eint = 3'b000;
        ticks(4);
    endtask

    task automatic test_mask_w1c();
        wr(8'h00, 8'h00);
        eint[1] = 1'b1;
        ticks(3);
        rd(8'h01, 8'h02);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s3_masked_pend got %h want %h", data_o, e); end
        vec++; if (irq !== 1'b0) begin miss++; $display("FAIL s3_masked_irq got %b want 0", irq); end
        wr(8'h00, 8'h02);
        vec++; if (irq !== 1'b0) begin miss++; $display("FAIL s3_unmask_early got %b want 0", irq); end
        tick();
        vec++; if ({irq, irq_id} !== {1'b1, 3'd1}) begin miss++; $display("FAIL s3_unmask_req got %b/%0d want 1/1", irq, irq_id); end
        wr(8'h01, 8'h02);
        tick();
        vec++; if (irq !== 1'b0) begin miss++; $display("FAIL s3_w1c_drop got %b want 0", irq); end
        rd(8'h04, 8'h00);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s3_stat got %h want %h", data_o, e); end
    endtask

    task automatic test_level();
        wr(8'h03, 8'h01);
        wr(8'h02, 8'h01);
        wr(8'h00, 8'h01);
        tick();
        vec++; if ({irq, irq_id, int_vec} !== {1'b1, 3'd0, 3'b001}) begin miss++; $display("FAIL s4_level_req got %b/%0d/%b want 1/0/001", irq, irq_id, int_vec); end
        pulse_ack();
        rd(8'h01, 8'h01);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s4_pend_held got %h want %h", data_o, e); end
        wr(8'h05, 8'h00);
        vec++; if (irq !== 1'b0) begin miss++; $display("FAIL s4_eoi_gap got %b want 0", irq); end
        tick();
        vec++; if ({irq, irq_id} !== {1'b1, 3'd0}) begin miss++; $display("FAIL s4_reassert got %b/%0d want 1/0", irq, irq_id); end
        eint[0] = 1'b1;
        ticks(3);
        rd(8'h01, 8'h00);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s4_release got %h want %h", data_o, e); end
        tick();
        vec++; if (irq !== 1'b0) begin miss++; $display("FAIL s4_release_irq got %b want 0", irq); end
        wr(8'h03, 8'h00);
        wr(8'h02, 8'h00);
    endtask

    task automatic test_set_vs_clear();
        eint[1] = 1'b0;
        ticks(4);
        eint[1] = 1'b1;
        ticks(2);
        wr(8'h01, 8'h02);
        rd(8'h01, 8'h02);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s5_set_wins got %h want %h", data_o, e); end
        wr(8'h01, 8'h02);
        rd(8'h01, 8'h00);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s5_w1c got %h want %h", data_o, e); end
        rd(8'h06, 8'h00);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s5_off6 got %h want %h", data_o, e); end
        rd(8'h05, 8'h00);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s5_eoi_rd got %h want %h", data_o, e); end
        wr(8'h00, 8'hFF);
        rd(8'h00, 8'h07);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s5_mask_width got %h want %h", data_o, e); end
        vec++; if (data_o8 !== 8'hFF) begin miss++; $display("FAIL s5_mask8 got %h want ff", data_o8); end
    endtask

    task automatic test_reset_busy();
        eint = 3'b000;
        ticks(4);
        eint = 3'b101;
        ticks(3);
        rd(8'h01, 8'h05);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s6_pend got %h want %h", data_o, e); end
        pulse_ack();
        eint[0] = 1'b0;
        ticks(3);
        eint[0] = 1'b1;
        ticks(3);
        rd(8'h01, 8'h05);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s6_busy_pend got %h want %h", data_o, e); end
        rd(8'h04, 8'h40);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s6_busy_stat got %h want %h", data_o, e); end
        eint = 3'b000;
        NRST = 1'b0;
        tick();
        vec++; if ({irq, irq_id, int_vec, data_o} !== 15'd0) begin miss++; $display("FAIL s6_rst_outs got %b/%0d/%b/%h want all 0", irq, irq_id, int_vec, data_o); end
        NRST = 1'b1;
        rd(8'h04, 8'h00);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s6_rst_stat got %h want %h", data_o, e); end
        rd(8'h01, 8'h00);
        e = sb.pop_front(); vec++; if (data_o !== e) begin miss++; $display("FAIL s6_rst_pend got %h want %h", data_o, e); end
    endtask

    task automatic test_eight_channels();
        wr(8'h00, 8'hFF);
        eint8[1] = 1'b1;
        ticks(3);
        vec++; if (irq8 !== 1'b0) begin miss++; $display("FAIL n8_irq_early got %b want 0", irq8); end
        rd(8'h01, 8'h02);
        e = sb.pop_front(); vec++; if (data_o8 !== e) begin miss++; $display("FAIL n8_pend got %h want %h", data_o8, e); end
        vec++; if ({irq8, irq_id8, int_vec8} !== {1'b1, 3'd1, 8'h02}) begin miss++; $display("FAIL n8_req got %b/%0d/%h want 1/1/02", irq8, irq_id8, int_vec8); end
        pulse_ack();
        rd(8'h04, 8'h41);
        e = sb.pop_front(); vec++; if (data_o8 !== e) begin miss++; $display("FAIL n8_stat_busy got %h want %h", data_o8, e); end
        wr(8'h05, 8'h00);
        rd(8'h04, 8'h00);
        e = sb.pop_front(); vec++; if (data_o8 !== e) begin miss++; $display("FAIL n8_stat_idle got %h want %h", data_o8, e); end
        eint8 = 8'h8A;
        ticks(3);
        rd(8'h01, 8'h88);
        e = sb.pop_front(); vec++; if (data_o8 !== e) begin miss++; $display("FAIL n8_pend_hi got %h want %h", data_o8, e); end
        vec++; if ({irq8, irq_id8, int_vec8} !== {1'b1, 3'd3, 8'h08}) begin miss++; $display("FAIL n8_req3 got %b/%0d/%h want 1/3/08", irq8, irq_id8, int_vec8); end
        pulse_ack();
        rd(8'h01, 8'h80);
        e = sb.pop_front(); vec++; if (data_o8 !== e) begin miss++; $display("FAIL n8_pend_after got %h want %h", data_o8, e); end
        wr(8'h05, 8'h00);
        tick();
        vec++; if ({irq8, irq_id8, int_vec8} !== {1'b1, 3'd7, 8'h80}) begin miss++; $display("FAIL n8_req7 got %b/%0d/%h want 1/7/80", irq8, irq_id8, int_vec8); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_edge();
        test_priority_back_to_back();
        test_mask_w1c();
        test_level();
        test_set_vs_clear();
        test_reset_busy();
        test_eight_channels();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
